// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared encodings for the RV32I pipeline writeback and decode logic.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/wb_result_mux.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_mux
// Brief    : Combinational writeback result select (ALU / load / PC+4 / zero).
// Revision : 1.0
// ============================================================================
module wb_result_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_src,
    input  logic [XLEN-1:0] i_alu,
    input  logic [XLEN-1:0] i_mem,
    input  logic [XLEN-1:0] i_pc4,
    output logic [XLEN-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_src)
            RES_ALU: o_result = i_alu;
            RES_MEM: o_result = i_mem;
            RES_PC4: o_result = i_pc4;
            // The reserved encoding yields zero so a stray commit is deterministic.
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : Writeback stage and x0..x31 register file with WB->ID bypass.
// Revision : 1.0
// ============================================================================
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    parameter int CNTW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            regwrite_W,
    input  logic [1:0]      result_src_W,
    input  logic [XLEN-1:0] aluresult_W,
    input  logic [XLEN-1:0] readData_W,
    input  logic [4:0]      Rd_W,
    input  logic [XLEN-1:0] pcplus4_W,
    input  logic [4:0]      Rs1_D,
    input  logic [4:0]      Rs2_D,
    output logic [XLEN-1:0] rd1_D,
    output logic [XLEN-1:0] rd2_D,
    output logic [XLEN-1:0] result_W,
    output logic [CNTW-1:0] wb_count
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [CNTW-1:0] r_count;
    logic            w_commit;
    logic            w_byp1;
    logic            w_byp2;

    wb_result_mux #(
        .XLEN (XLEN)
    ) u_result_mux (
        .i_src    (result_src_W),
        .i_alu    (aluresult_W),
        .i_mem    (readData_W),
        .i_pc4    (pcplus4_W),
        .o_result (result_W)
    );

    assign w_commit = regwrite_W && (Rd_W != REG_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else if (w_commit) begin
            r_regs[Rd_W] <= result_W;
            r_count      <= r_count + CNTW'(1);
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_byp1 = w_commit && (Rs1_D == Rd_W);
            assign w_byp2 = w_commit && (Rs2_D == Rd_W);
        end else begin : g_no_bypass
            assign w_byp1 = 1'b0;
            assign w_byp2 = 1'b0;
        end
    endgenerate

    // x0 is forced to zero here rather than relying on the array entry.
    always_comb begin
        rd1_D = r_regs[Rs1_D];
        if (Rs1_D == REG_ZERO) begin
            rd1_D = '0;
        end else if (w_byp1) begin
            rd1_D = result_W;
        end
    end

    always_comb begin
        rd2_D = r_regs[Rs2_D];
        if (Rs2_D == REG_ZERO) begin
            rd2_D = '0;
        end else if (w_byp2) begin
            rd2_D = result_W;
        end
    end

    assign wb_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Scoreboard bench for wb_regfile (bypassing/32-bit count and raw/4-bit count builds).
// Revision : 1.0
// ============================================================================
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        regwrite_W;
    logic [1:0]  result_src_W;
    logic [31:0] aluresult_W, readData_W, pcplus4_W;
    logic [4:0]  Rd_W, Rs1_D, Rs2_D;
    logic [31:0] rd1_D, rd2_D, result_W, wb_count;
    logic [31:0] rd1_raw, rd2_raw, result_raw;
    logic [3:0]  wb_count4;

    always #5 clk = ~clk;

    wb_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1), .CNTW(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .regwrite_W(regwrite_W), .result_src_W(result_src_W),
        .aluresult_W(aluresult_W), .readData_W(readData_W), .Rd_W(Rd_W), .pcplus4_W(pcplus4_W),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .rd1_D(rd1_D), .rd2_D(rd2_D),
        .result_W(result_W), .wb_count(wb_count)
    );

    wb_regfile #(.XLEN(32), .NREGS(32), .BYPASS(0), .CNTW(4)) u_dut_raw (
        .clk(clk), .rst_n(rst_n), .regwrite_W(regwrite_W), .result_src_W(result_src_W),
        .aluresult_W(aluresult_W), .readData_W(readData_W), .Rd_W(Rd_W), .pcplus4_W(pcplus4_W),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .rd1_D(rd1_raw), .rd2_D(rd2_raw),
        .result_W(result_raw), .wb_count(wb_count4)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] rd1_raw;
        logic [31:0] rd2_raw;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
        int          tag;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    bit          m_valid = 1'b0;
    int          total = 0;
    int          bad = 0;

    // Architectural view: x0 reads zero, a same-cycle committing write is visible when bypassing.
    function automatic logic [31:0] model_read(input logic [4:0] rs, input bit byp,
                                               input logic we, input logic [4:0] rd,
                                               input logic [31:0] res);
        if (rs == 5'd0) return 32'd0;
        if (byp && we && rd != 5'd0 && rs == rd) return res;
        return m_regs[rs];
    endfunction

    task automatic step(input logic rst, input logic we, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc4,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input int tag);
        exp_t        e;
        logic [31:0] res;
        rst_n = rst; regwrite_W = we; result_src_W = src;
        aluresult_W = alu; readData_W = rdat; pcplus4_W = pc4;
        Rd_W = rd; Rs1_D = rs1; Rs2_D = rs2;
        case (src)
            2'd0:    res = alu;
            2'd1:    res = rdat;
            2'd2:    res = pc4;
            default: res = 32'd0;
        endcase
        if (m_valid) begin
            e.res     = res;
            e.rd1     = model_read(rs1, 1'b1, we, rd, res);
            e.rd2     = model_read(rs2, 1'b1, we, rd, res);
            e.rd1_raw = model_read(rs1, 1'b0, we, rd, res);
            e.rd2_raw = model_read(rs2, 1'b0, we, rd, res);
            e.cnt     = m_cnt;
            e.cnt4    = 4'(m_cnt % 16);
            e.tag     = tag;
            q.push_back(e);
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt   = 32'd0;
            m_valid = 1'b1;
        end else if (we && rd != 5'd0) begin
            m_regs[rd] = res;
            m_cnt      = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want,
                       input int tag);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s tag=%0d got=%h want=%h", name, tag, act, want);
        end
    endtask

    // Monitor: combinational outputs are presented every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("result",   result_W,        e.res,     e.tag);
                chk("rd1",      rd1_D,           e.rd1,     e.tag);
                chk("rd2",      rd2_D,           e.rd2,     e.tag);
                chk("rd1_raw",  rd1_raw,         e.rd1_raw, e.tag);
                chk("rd2_raw",  rd2_raw,         e.rd2_raw, e.tag);
                chk("count",    wb_count,        e.cnt,     e.tag);
                chk("count4",   {28'd0, wb_count4}, {28'd0, e.cnt4}, e.tag);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog tag=0 got=timeout want=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] rd, rs1, rs2;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0);

        // Reset clears earlier writes; a write coincident with reset is lost.
        step(1'b1, 1'b1, 2'd0, 32'h55, 32'd0, 32'd0, 5'd5, 5'd5, 5'd0, 1);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5, 1);
        step(1'b0, 1'b1, 2'd0, 32'h66, 32'd0, 32'd0, 5'd5, 5'd5, 5'd0, 1);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5, 1);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5, 1);

        step(1'b1, 1'b1, 2'd0, 32'hDEADBEEF, 32'd0, 32'd0, 5'd7, 5'd0, 5'd0, 2);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd0, 2);

        step(1'b1, 1'b1, 2'd0, 32'h1234, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd7, 3);

        step(1'b1, 1'b1, 2'd1, 32'h1, 32'hCAFE0001, 32'h2, 5'd3, 5'd3, 5'd3, 4);
        step(1'b1, 1'b0, 2'd3, 32'h1, 32'h2, 32'h3, 5'd3, 5'd3, 5'd3, 4);

        step(1'b1, 1'b1, 2'd2, 32'h1, 32'h2, 32'h0000_0104, 5'd1, 5'd0, 5'd1, 5);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd0, 5);
        step(1'b0, 1'b1, 2'd2, 32'h1, 32'h2, 32'h0000_0104, 5'd1, 5'd0, 5'd1, 5);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd3, 5);

        // Reserved select commits zero; then drive the 4-bit counter through its wrap.
        step(1'b1, 1'b1, 2'd0, 32'hAAAA, 32'd0, 32'd0, 5'd9, 5'd9, 5'd0, 6);
        step(1'b1, 1'b1, 2'd3, 32'hBBBB, 32'h1, 32'h2, 5'd9, 5'd0, 5'd9, 6);
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b1, 2'd0, 32'h100 + 32'(i), 32'd0, 32'd0, 5'(i % 31 + 1),
                 5'd9, 5'(i % 31 + 1), 6);
        end

        for (int i = 0; i < 500; i++) begin
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            rs1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 39) != 0), 1'($urandom), 2'($urandom),
                 $urandom, $urandom, $urandom, rd, rs1, rs2, 100);
        end

        repeat (2) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain tag=0 got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
